// File: rtl/beta_mem_arbiter.sv
// beta_mem_arbiter
// Shares one memory port between instruction fetch reads (if_*), LSU reads
// (lr_*) and LSU writes (lw_*). Only one transaction is in flight at a time.
// Writes win over reads, and LSU reads win over fetch. A fetch request that
// keeps losing is promoted once it has lost StarveLimit arbitrations in a row.
// If the memory never responds, the transaction is aborted and the owner
// receives a valid pulse with zero data.
//
// Ports
//   clk_i, rstn_i           clock, synchronous active-low reset
//   if_req_i/if_addr_i      fetch read request, held until if_ready_o
//   if_ready_o/if_valid_o   fetch accept pulse / response pulse
//   if_rdata_o              fetch read data (nonzero only with if_valid_o)
//   lr_*                    LSU read channel, same handshake, with byte strobe
//   lw_*                    LSU write channel, same handshake, no read data
//   mem_req_o..mem_strb_o   memory request, held until mem_ready_i
//   mem_ready_i             memory accepts the request this cycle
//   mem_valid_i/mem_rdata_i memory response
//   arb_err_o               one-cycle pulse when a response times out
//   arb_busy_o              a transaction is being issued or awaited
//
// State table
//   state     | meaning
//   ST_IDLE   | no transaction; arbitrate among the pending requests
//   ST_ISSUE  | drive the latched request until the memory accepts it
//   ST_WAIT   | request accepted; wait for the response or the timeout
module beta_mem_arbiter #(
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int StarveLimit   = 4,
  parameter int TimeoutCycles = 64
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    if_req_i,
  input  logic [AddressWidth-1:0] if_addr_i,
  output logic                    if_ready_o,
  output logic                    if_valid_o,
  output logic [DataWidth-1:0]    if_rdata_o,
  input  logic                    lr_req_i,
  input  logic [AddressWidth-1:0] lr_addr_i,
  input  logic [DataWidth/8-1:0]  lr_strb_i,
  output logic                    lr_ready_o,
  output logic                    lr_valid_o,
  output logic [DataWidth-1:0]    lr_rdata_o,
  input  logic                    lw_req_i,
  input  logic [AddressWidth-1:0] lw_addr_i,
  input  logic [DataWidth-1:0]    lw_wdata_i,
  input  logic [DataWidth/8-1:0]  lw_strb_i,
  output logic                    lw_ready_o,
  output logic                    lw_valid_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddressWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0]    mem_wdata_o,
  output logic [DataWidth/8-1:0]  mem_strb_o,
  input  logic                    mem_ready_i,
  input  logic                    mem_valid_i,
  input  logic [DataWidth-1:0]    mem_rdata_i,
  output logic                    arb_err_o,
  output logic                    arb_busy_o
);

  localparam int StrbWidth   = DataWidth / 8;
  localparam int TimerWidth  = $clog2(TimeoutCycles) + 1;
  localparam int StarveWidth = $clog2(StarveLimit + 1);

  localparam logic [StarveWidth-1:0] StarveMax = StarveWidth'(StarveLimit);
  localparam logic [TimerWidth-1:0]  TimerLast = TimerWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LR, OWN_LW} owner_e;

  state_e                  state_q, state_d;
  owner_e                  owner_q, owner_d;
  owner_e                  grant;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [StrbWidth-1:0]    strb_q, strb_d;
  logic                    we_q, we_d;
  logic [StarveWidth-1:0]  starve_q, starve_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;

  logic accept;
  logic timeout_hit;
  logic resp_fire;
  logic resp_data;

  // A starved fetch outranks everything; otherwise fixed priority.
  always_comb begin
    grant = OWN_NONE;
    if (if_req_i && (starve_q == StarveMax)) grant = OWN_IF;
    else if (lw_req_i)                       grant = OWN_LW;
    else if (lr_req_i)                       grant = OWN_LR;
    else if (if_req_i)                       grant = OWN_IF;
  end

  assign accept      = (state_q == ST_ISSUE) && mem_ready_i;
  // A real response in the last cycle wins over the timeout.
  assign timeout_hit = (state_q == ST_WAIT) && !mem_valid_i && (timer_q == TimerLast);
  assign resp_data   = (state_q == ST_WAIT) && mem_valid_i;
  assign resp_fire   = resp_data || timeout_hit;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    we_d     = we_q;
    starve_d = starve_q;
    timer_d  = timer_q;
    case (state_q)
      ST_IDLE: begin
        // if_req_i high always produces an arbitration, so "not granted" means it lost.
        if (!if_req_i || grant == OWN_IF) starve_d = '0;
        else if (starve_q != StarveMax)   starve_d = starve_q + 1'b1;
        if (grant != OWN_NONE) begin
          state_d = ST_ISSUE;
          owner_d = grant;
          case (grant)
            OWN_LW: begin
              addr_d  = lw_addr_i;
              wdata_d = lw_wdata_i;
              strb_d  = lw_strb_i;
              we_d    = 1'b1;
            end
            OWN_LR: begin
              addr_d  = lr_addr_i;
              wdata_d = '0;
              strb_d  = lr_strb_i;
              we_d    = 1'b0;
            end
            default: begin
              addr_d  = if_addr_i;
              wdata_d = '0;
              strb_d  = '1;
              we_d    = 1'b0;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        if (mem_ready_i) begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end
      ST_WAIT: begin
        if (resp_fire) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      we_q     <= 1'b0;
      starve_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      we_q     <= we_d;
      starve_q <= starve_d;
      timer_q  <= timer_d;
    end
  end

  // Bus outputs are only driven while issuing so the port idles at zero.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;
    if (state_q == ST_ISSUE) begin
      mem_req_o   = 1'b1;
      mem_we_o    = we_q;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      mem_strb_o  = strb_q;
    end
  end

  always_comb begin
    if_ready_o = accept && (owner_q == OWN_IF);
    lr_ready_o = accept && (owner_q == OWN_LR);
    lw_ready_o = accept && (owner_q == OWN_LW);
    if_valid_o = resp_fire && (owner_q == OWN_IF);
    lr_valid_o = resp_fire && (owner_q == OWN_LR);
    lw_valid_o = resp_fire && (owner_q == OWN_LW);
    if_rdata_o = (resp_data && owner_q == OWN_IF) ? mem_rdata_i : '0;
    lr_rdata_o = (resp_data && owner_q == OWN_LR) ? mem_rdata_i : '0;
  end

  assign arb_err_o  = timeout_hit;
  assign arb_busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_beta_mem_arbiter.sv
module tb_beta_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o, if_valid_o;
  logic [31:0] if_rdata_o;
  logic        lr_req_i;
  logic [31:0] lr_addr_i;
  logic [3:0]  lr_strb_i;
  logic        lr_ready_o, lr_valid_o;
  logic [31:0] lr_rdata_o;
  logic        lw_req_i;
  logic [31:0] lw_addr_i;
  logic [31:0] lw_wdata_i;
  logic [3:0]  lw_strb_i;
  logic        lw_ready_o, lw_valid_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_strb_o;
  logic        mem_ready_i, mem_valid_i;
  logic [31:0] mem_rdata_i;
  logic        arb_err_o, arb_busy_o;

  int errors = 0;
  int checks = 0;

  beta_mem_arbiter #(
    .DataWidth(32), .AddressWidth(32), .StarveLimit(4), .TimeoutCycles(64)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ready_o(if_ready_o), .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .lr_req_i(lr_req_i), .lr_addr_i(lr_addr_i), .lr_strb_i(lr_strb_i),
    .lr_ready_o(lr_ready_o), .lr_valid_o(lr_valid_o), .lr_rdata_o(lr_rdata_o),
    .lw_req_i(lw_req_i), .lw_addr_i(lw_addr_i), .lw_wdata_i(lw_wdata_i),
    .lw_strb_i(lw_strb_i), .lw_ready_o(lw_ready_o), .lw_valid_o(lw_valid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
    .arb_err_o(arb_err_o), .arb_busy_o(arb_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    logic exp_if;
    rstn_i = 1'b0;
    if_req_i = 0; if_addr_i = 0;
    lr_req_i = 0; lr_addr_i = 0; lr_strb_i = 0;
    lw_req_i = 0; lw_addr_i = 0; lw_wdata_i = 0; lw_strb_i = 0;
    mem_ready_i = 0; mem_valid_i = 0; mem_rdata_i = 0;

    // Reset state
    tick(); tick(); #1;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_busy", arb_busy_o, 0);
    chk("rst_err", arb_err_o, 0);
    chk("rst_valids", {if_valid_o, lr_valid_o, lw_valid_o}, 0);
    chk("rst_rdata", {if_rdata_o, lr_rdata_o}, 0);
    rstn_i = 1'b1;

    // Single LSU read
    tick();
    lr_req_i = 1; lr_addr_i = 32'h100; lr_strb_i = 4'hF; #1;
    chk("lr_idle_req", mem_req_o, 0);
    tick(); #1;
    chk("lr_issue_req", mem_req_o, 1);
    chk("lr_issue_addr", mem_addr_o, 32'h100);
    chk("lr_issue_we", mem_we_o, 0);
    chk("lr_issue_strb", mem_strb_o, 4'hF);
    chk("lr_issue_busy", arb_busy_o, 1);
    chk("lr_no_early_ready", lr_ready_o, 0);
    tick(); mem_ready_i = 1; #1;
    chk("lr_ready", lr_ready_o, 1);
    chk("lr_other_ready", {if_ready_o, lw_ready_o}, 0);
    tick(); lr_req_i = 0; mem_ready_i = 0; #1;
    chk("lr_wait_req", mem_req_o, 0);
    chk("lr_wait_valid", lr_valid_o, 0);
    tick(); mem_valid_i = 1; mem_rdata_i = 32'hDEADBEEF; #1;
    chk("lr_valid", lr_valid_o, 1);
    chk("lr_rdata", lr_rdata_o, 32'hDEADBEEF);
    chk("lr_other_valid", {if_valid_o, lw_valid_o}, 0);
    chk("lr_if_rdata", if_rdata_o, 0);
    tick(); mem_valid_i = 0; #1;
    chk("lr_back_idle", arb_busy_o, 0);

    // LW and LR together: write first, read right after
    lw_req_i = 1; lw_addr_i = 32'h200; lw_wdata_i = 32'hCAFEF00D; lw_strb_i = 4'h3;
    lr_req_i = 1; lr_addr_i = 32'h104; lr_strb_i = 4'hC;
    tick(); #1;
    chk("lw_issue_we", mem_we_o, 1);
    chk("lw_issue_addr", mem_addr_o, 32'h200);
    chk("lw_issue_wdata", mem_wdata_o, 32'hCAFEF00D);
    chk("lw_issue_strb", mem_strb_o, 4'h3);
    mem_ready_i = 1; #1;
    chk("lw_ready", {lw_ready_o, lr_ready_o}, 2'b10);
    tick(); lw_req_i = 0; mem_ready_i = 0; mem_valid_i = 1; mem_rdata_i = 32'h77777777; #1;
    chk("lw_valid", {lw_valid_o, lr_valid_o}, 2'b10);
    chk("lw_no_rdata", {if_rdata_o, lr_rdata_o}, 0);
    tick(); mem_valid_i = 0; #1;
    chk("lw_done_idle", arb_busy_o, 0);
    tick(); #1;
    chk("lr2_issue_we", mem_we_o, 0);
    chk("lr2_issue_addr", mem_addr_o, 32'h104);
    chk("lr2_issue_strb", mem_strb_o, 4'hC);
    mem_ready_i = 1; #1;
    chk("lr2_ready", lr_ready_o, 1);
    tick(); lr_req_i = 0; mem_ready_i = 0; mem_valid_i = 1; mem_rdata_i = 32'h12345678; #1;
    chk("lr2_rdata", lr_rdata_o, 32'h12345678);
    tick(); mem_valid_i = 0;

    // Starvation guard: IF loses four times, wins the fifth, then counts from 0 again
    if_req_i = 1; if_addr_i = 32'h40; lr_req_i = 1; lr_addr_i = 32'h300; lr_strb_i = 4'h1;
    for (int a = 1; a <= 6; a++) begin
      tick(); #1;
      exp_if = (a == 5);
      chk("starve_addr", mem_addr_o, exp_if ? 32'h40 : 32'h300);
      chk("starve_strb", mem_strb_o, exp_if ? 4'hF : 4'h1);
      mem_ready_i = 1; #1;
      chk("starve_if_ready", if_ready_o, exp_if);
      chk("starve_lr_ready", lr_ready_o, !exp_if);
      tick(); mem_ready_i = 0;
      if (a == 6) begin if_req_i = 0; lr_req_i = 0; end
      mem_valid_i = 1; mem_rdata_i = 32'h1000 + a; #1;
      chk("starve_if_valid", if_valid_o, exp_if);
      chk("starve_if_rdata", if_rdata_o, exp_if ? 32'h1005 : 32'h0);
      tick(); mem_valid_i = 0;
    end

    // Memory stalls accept for 10 cycles, then the response never arrives
    lr_req_i = 1; lr_addr_i = 32'h500; lr_strb_i = 4'hF;
    tick();
    for (int c = 1; c <= 10; c++) begin
      #1;
      chk("stall_req", mem_req_o, 1);
      chk("stall_addr", mem_addr_o, 32'h500);
      chk("stall_ready", lr_ready_o, 0);
      tick();
    end
    mem_ready_i = 1; #1;
    chk("stall_grant11", lr_ready_o, 1);
    tick(); lr_req_i = 0; mem_ready_i = 0; mem_rdata_i = 32'hFFFFFFFF;
    for (int w = 1; w <= 64; w++) begin
      #1;
      chk("to_err", arb_err_o, (w == 64));
      chk("to_valid", lr_valid_o, (w == 64));
      chk("to_rdata", lr_rdata_o, 0);
      tick();
    end
    #1;
    chk("to_idle", arb_busy_o, 0);
    chk("to_err_done", arb_err_o, 0);

    // Reset during WAIT drops the outstanding response
    lr_req_i = 1; lr_addr_i = 32'h600;
    tick(); mem_ready_i = 1;
    tick(); lr_req_i = 0; mem_ready_i = 0; #1;
    chk("rw_in_wait", arb_busy_o, 1);
    rstn_i = 0;
    tick(); mem_valid_i = 1; mem_rdata_i = 32'h55; #1;
    chk("rw_valid", lr_valid_o, 0);
    chk("rw_rdata", lr_rdata_o, 0);
    chk("rw_busy", arb_busy_o, 0);
    chk("rw_req", mem_req_o, 0);
    rstn_i = 1;
    tick(); #1;
    chk("rw_idle_valid_ignored", {if_valid_o, lr_valid_o, lw_valid_o}, 0);
    mem_valid_i = 0;
    if_req_i = 1; if_addr_i = 32'h80;
    tick(); #1;
    chk("rw_next_addr", mem_addr_o, 32'h80);
    mem_ready_i = 1; #1;
    chk("rw_next_ready", if_ready_o, 1);
    tick(); if_req_i = 0; mem_ready_i = 0; mem_valid_i = 1; mem_rdata_i = 32'h0BADF00D; #1;
    chk("rw_next_valid", if_valid_o, 1);
    chk("rw_next_rdata", if_rdata_o, 32'h0BADF00D);
    tick(); mem_valid_i = 0; #1;
    chk("rw_final_idle", arb_busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
